ysyx_22040127_memory: RTL and testbench
=======================================

YSYX_22040127_MEMORY -- requirements
Module: ysyx_22040127_memory

Interface
REQ-001 SHALL have the ports below; single clock domain; reset is synchronous and active-low.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-low.
REQ-004 ex_to_mem_valid  in  1  upstream holds a valid instruction.
REQ-005 mem_allowin  out  1  stage can accept a new instruction this cycle.
REQ-006 ex_memread / ex_memwrite / ex_reg_wen  in  1 each  load, store and register-write flags.
REQ-007 ex_memop  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 ex_alu_output  in  64  ALU result, or byte address for loads and stores.
REQ-009 ex_mem_wdata  in  64  store data, right-aligned.
REQ-010 ex_rd  in  5 and ex_pc  in  32  destination register and PC.
REQ-011 mem_flush  in  1  kill the instruction held in this stage.
REQ-012 wb_allowin  in  1  downstream can accept.
REQ-013 mem_to_wb_valid  out  1 and mem_to_wb_result  out  64  result handoff to writeback.
REQ-014 mem_to_wb_rd  out  5, mem_to_wb_wen  out  1, mem_to_wb_pc  out  32  writeback information.
REQ-015 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  64, dmem_wdata  out  64, dmem_wstrb  out  8  data-bus request.
REQ-016 dmem_gnt  in  1, dmem_rvalid  in  1, dmem_rdata  in  64  grant, response and read data.
REQ-017 mem_fwd_valid  out  1 and mem_fwd_rd  out  5  hazard/forward tag, active while the held instruction will write rd.
REQ-018 mem_misalign  out  1  the held access crosses an 8-byte boundary.

Function
REQ-019 Capture: inputs are latched when ex_to_mem_valid and mem_allowin are both high; mem_valid then becomes ex_to_mem_valid.
REQ-020 FSM states: IDLE, REQ, WAIT, DONE.
REQ-021 Non-memory op: stays in IDLE; result = ex_alu_output; mem_to_wb_valid asserts the cycle after capture.
REQ-022 Memory op: IDLE goes to REQ the cycle after capture.
REQ-023 In REQ: dmem_req=1 and it stays high until dmem_gnt; on a grant the FSM goes to WAIT.
REQ-024 In WAIT: on dmem_rvalid (this also acknowledges stores) the FSM goes to DONE and the load result is registered.
REQ-025 Minimum load/store latency: 3 cycles from capture to mem_to_wb_valid (gnt in the first REQ cycle, rvalid the next cycle).
REQ-026 DONE holds mem_to_wb_valid and the result until wb_allowin, then returns to IDLE.
REQ-027 mem_allowin = !mem_valid | (ready_go & wb_allowin); ready_go = (IDLE & non-memory op) | DONE.
REQ-028 Back-to-back acceptance in the same cycle as a handoff is required.
REQ-029 dmem_addr = {addr[63:3], 3'b000}.
REQ-030 dmem_wstrb = size mask (1, 3, F or FF hex) shifted left by addr[2:0].
REQ-031 dmem_wdata = ex_mem_wdata shifted left by 8*addr[2:0].
REQ-032 dmem_we = ex_memwrite; all dmem outputs are constant for as long as dmem_req is high.
REQ-033 Load result = dmem_rdata >> 8*addr[2:0], truncated to the access size, then sign-extended for b/h/w and zero-extended for bu/hu/wu/d.
REQ-034 mem_misalign = mem_valid & memory op & (addr[2:0] + size_bytes > 8); the access is still issued, truncated by wstrb.
REQ-035 Flush in IDLE or DONE: mem_valid clears next cycle and no handoff occurs.
REQ-036 Flush in REQ with no grant that cycle: dmem_req drops, mem_valid clears and the FSM goes to IDLE.
REQ-037 Flush in REQ with a grant, or flush in WAIT: the FSM continues to DONE, the response is discarded, and mem_to_wb_valid stays 0.
REQ-038 During a REQ-037 drain, mem_allowin=0 until the FSM returns to IDLE; a flush is treated as sticky until then.
REQ-039 A flush in the same cycle as capture discards the incoming instruction.
REQ-040 mem_fwd_valid = mem_valid & ex_reg_wen & (rd != 0) & no pending flush.

Reset
REQ-041 While rst=0: FSM=IDLE, mem_valid=0, dmem_req=0, mem_to_wb_valid=0, mem_fwd_valid=0, latched fields=0, mem_allowin=1 after release.
REQ-042 Reset mid-transaction abandons the transaction; a late dmem_rvalid arriving in IDLE SHALL be ignored.

Verification
REQ-043 addi rd=5, result 0x2A, wb_allowin=1 -> mem_to_wb_valid asserts the cycle after capture, result=0x2A, no dmem_req.
REQ-044 lb at addr 0x1003, rdata=0x00000000_80000000, gnt immediate, rvalid one cycle later -> result 0xFFFFFFFF_FFFFFF80 at 3-cycle latency; lbu at the same address -> 0x80.
REQ-045 sh at addr 0x2006, wdata=0xBEEF -> dmem_addr=0x2000, wstrb=0xC0, wdata=0xBEEF0000_00000000, we=1.
REQ-046 Load with gnt withheld 4 cycles -> dmem_req and address stable for all 4 cycles, mem_allowin=0 throughout.
REQ-047 Flush raised during WAIT -> no mem_to_wb_valid; mem_allowin returns to 1 only after rvalid; the next instruction completes normally.
REQ-048 lw at addr 0x3006 -> mem_misalign=1, wstrb=0xC0; reset asserted during WAIT -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/ysyx_22040127_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040127_memory_if
//  Description : Data-memory bus between the MEM stage (master) and the
//                data memory (slave): request/grant plus read response.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_22040127_memory_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040127_memory.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040127_memory
//  Description : Pipeline MEM stage. Holds one instruction, issues aligned
//                data-bus accesses with byte strobes, extracts/extends load
//                data and hands the result to writeback. Handles flushes,
//                including draining an access already granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040127_memory (
    input  wire        clk,
    input  wire        rst,
    input  wire        ex_to_mem_valid,
    output logic       mem_allowin,
    input  wire        ex_memread,
    input  wire        ex_memwrite,
    input  wire        ex_reg_wen,
    input  wire [2:0]  ex_memop,
    input  wire [63:0] ex_alu_output,
    input  wire [63:0] ex_mem_wdata,
    input  wire [4:0]  ex_rd,
    input  wire [31:0] ex_pc,
    input  wire        mem_flush,
    input  wire        wb_allowin,
    output logic       mem_to_wb_valid,
    output logic [63:0] mem_to_wb_result,
    output logic [4:0] mem_to_wb_rd,
    output logic       mem_to_wb_wen,
    output logic [31:0] mem_to_wb_pc,
    ysyx_22040127_memory_if.master dmem,
    output logic       mem_fwd_valid,
    output logic [4:0] mem_fwd_rd,
    output logic       mem_misalign
);

    localparam logic [2:0] c_op_b  = 3'b000;
    localparam logic [2:0] c_op_h  = 3'b001;
    localparam logic [2:0] c_op_w  = 3'b010;
    localparam logic [2:0] c_op_bu = 3'b100;
    localparam logic [2:0] c_op_hu = 3'b101;
    localparam logic [2:0] c_op_wu = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_mem_valid;
    logic        r_flush_pend;
    logic        r_memread;
    logic        r_memwrite;
    logic        r_reg_wen;
    logic [2:0]  r_memop;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic [63:0] r_load_data;

    logic        w_is_mem;
    logic        w_ready_go;
    logic        w_capture;
    logic        w_drain_start;
    logic        w_req;
    logic [7:0]  w_size_mask;
    logic [3:0]  w_size_bytes;
    logic [63:0] w_rshift;
    logic [63:0] w_load_val;

    assign w_is_mem   = r_memread | r_memwrite;
    assign w_ready_go = ((r_state == S_IDLE) & ~w_is_mem) | (r_state == S_DONE);
    // A drain in progress blocks new work until the FSM is back in IDLE.
    assign mem_allowin = ~r_mem_valid | (w_ready_go & wb_allowin & ~r_flush_pend);
    assign w_capture   = ex_to_mem_valid & mem_allowin;
    // Once the bus has committed to the access we must still consume rvalid.
    assign w_drain_start = r_mem_valid & mem_flush &
                           (((r_state == S_REQ) & dmem.dmem_gnt) | (r_state == S_WAIT));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state: bus progress first, then a clean capture overrides the target
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_REQ: begin
                if (dmem.dmem_gnt)  w_state_nxt = S_WAIT;
                else if (mem_flush) w_state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (dmem.dmem_rvalid) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (r_flush_pend | mem_flush | wb_allowin) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_capture & ~mem_flush)
            w_state_nxt = (ex_memread | ex_memwrite) ? S_REQ : S_IDLE;
    end

    // Valid bit and sticky flush used while draining a granted access
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_valid  <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (r_flush_pend)       r_mem_valid <= (r_state != S_DONE);
            else if (w_drain_start) r_mem_valid <= 1'b1;
            else if (mem_flush)     r_mem_valid <= 1'b0;
            else if (mem_allowin)   r_mem_valid <= ex_to_mem_valid;

            if (r_state == S_DONE)  r_flush_pend <= 1'b0;
            else if (w_drain_start) r_flush_pend <= 1'b1;
        end
    end

    // Latch the instruction fields on acceptance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_reg_wen  <= 1'b0;
            r_memop    <= 3'd0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_rd       <= 5'd0;
            r_pc       <= 32'd0;
        end else if (w_capture) begin
            r_memread  <= ex_memread;
            r_memwrite <= ex_memwrite;
            r_reg_wen  <= ex_reg_wen;
            r_memop    <= ex_memop;
            r_addr     <= ex_alu_output;
            r_wdata    <= ex_mem_wdata;
            r_rd       <= ex_rd;
            r_pc       <= ex_pc;
        end
    end

    // Access size from funct3 low bits: 1, 2, 4 or 8 bytes
    always_comb begin
        w_size_mask  = 8'hFF;
        w_size_bytes = 4'd8;
        case (r_memop[1:0])
            2'd0: begin w_size_mask = 8'h01; w_size_bytes = 4'd1; end
            2'd1: begin w_size_mask = 8'h03; w_size_bytes = 4'd2; end
            2'd2: begin w_size_mask = 8'h0F; w_size_bytes = 4'd4; end
            default: begin w_size_mask = 8'hFF; w_size_bytes = 4'd8; end
        endcase
    end

    // Align read data to bit 0, then truncate and extend by access type
    always_comb begin
        w_rshift   = dmem.dmem_rdata >> {r_addr[2:0], 3'b000};
        w_load_val = w_rshift;
        case (r_memop)
            c_op_b:  w_load_val = {{56{w_rshift[7]}},  w_rshift[7:0]};
            c_op_h:  w_load_val = {{48{w_rshift[15]}}, w_rshift[15:0]};
            c_op_w:  w_load_val = {{32{w_rshift[31]}}, w_rshift[31:0]};
            c_op_bu: w_load_val = {56'd0, w_rshift[7:0]};
            c_op_hu: w_load_val = {48'd0, w_rshift[15:0]};
            c_op_wu: w_load_val = {32'd0, w_rshift[31:0]};
            default: w_load_val = w_rshift;
        endcase
    end

    // Register load data when the response arrives
    always_ff @(posedge clk) begin
        if (!rst)                                        r_load_data <= 64'd0;
        else if ((r_state == S_WAIT) & dmem.dmem_rvalid) r_load_data <= w_load_val;
    end

    // Bus outputs come only from latched state, so they cannot move during REQ
    assign w_req            = (r_state == S_REQ);
    assign dmem.dmem_req    = w_req;
    assign dmem.dmem_we     = w_req & r_memwrite;
    assign dmem.dmem_addr   = w_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign dmem.dmem_wstrb  = w_req ? (w_size_mask << r_addr[2:0]) : 8'd0;
    assign dmem.dmem_wdata  = w_req ? (r_wdata << {r_addr[2:0], 3'b000}) : 64'd0;

    assign mem_to_wb_valid  = r_mem_valid & w_ready_go & ~mem_flush & ~r_flush_pend;
    assign mem_to_wb_result = r_memread ? r_load_data : r_addr;
    assign mem_to_wb_rd     = r_rd;
    assign mem_to_wb_wen    = r_reg_wen;
    assign mem_to_wb_pc     = r_pc;

    assign mem_fwd_valid = r_mem_valid & r_reg_wen & (r_rd != 5'd0) & ~mem_flush & ~r_flush_pend;
    assign mem_fwd_rd    = r_rd;
    assign mem_misalign  = r_mem_valid & w_is_mem & (({1'b0, r_addr[2:0]} + w_size_bytes) > 4'd8);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22040127_memory
//  Description : Directed self-checking bench for the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_reg_wen;
    logic [2:0]  ex_memop;
    logic [63:0] ex_alu_output;
    logic [63:0] ex_mem_wdata;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc;
    logic        mem_flush;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [63:0] mem_to_wb_result;
    logic [4:0]  mem_to_wb_rd;
    logic        mem_to_wb_wen;
    logic [31:0] mem_to_wb_pc;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic        mem_misalign;

    int checks   = 0;
    int failures = 0;

    ysyx_22040127_memory_if dmem_bus();

    ysyx_22040127_memory dut (
        .clk              (clk),
        .rst              (rst),
        .ex_to_mem_valid  (ex_to_mem_valid),
        .mem_allowin      (mem_allowin),
        .ex_memread       (ex_memread),
        .ex_memwrite      (ex_memwrite),
        .ex_reg_wen       (ex_reg_wen),
        .ex_memop         (ex_memop),
        .ex_alu_output    (ex_alu_output),
        .ex_mem_wdata     (ex_mem_wdata),
        .ex_rd            (ex_rd),
        .ex_pc            (ex_pc),
        .mem_flush        (mem_flush),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_result (mem_to_wb_result),
        .mem_to_wb_rd     (mem_to_wb_rd),
        .mem_to_wb_wen    (mem_to_wb_wen),
        .mem_to_wb_pc     (mem_to_wb_pc),
        .dmem             (dmem_bus),
        .mem_fwd_valid    (mem_fwd_valid),
        .mem_fwd_rd       (mem_fwd_rd),
        .mem_misalign     (mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow #1 later.
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic rd_f, input logic wr_f, input logic wen,
                         input logic [2:0] op, input logic [63:0] alu,
                         input logic [63:0] wdata, input logic [4:0] rd,
                         input logic [31:0] pc);
        ex_to_mem_valid = 1'b1;
        ex_memread      = rd_f;
        ex_memwrite     = wr_f;
        ex_reg_wen      = wen;
        ex_memop        = op;
        ex_alu_output   = alu;
        ex_mem_wdata    = wdata;
        ex_rd           = rd;
        ex_pc           = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ex_to_mem_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_reg_wen = 1'b0;
        ex_memop = 3'd0; ex_alu_output = 64'd0; ex_mem_wdata = 64'd0; ex_rd = 5'd0; ex_pc = 32'd0;
        mem_flush = 1'b0; wb_allowin = 1'b1;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 64'd0;

        // Reset state
        repeat (3) next_cyc();
        #1;
        chk("rst_wb_valid", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("rst_req",      {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("rst_fwd",      {63'd0, mem_fwd_valid}, 64'd0);
        rst = 1'b1;
        next_cyc();

        // addi rd=5 -> handoff the cycle after capture, no bus request
        issue(1'b0, 1'b0, 1'b1, 3'b000, 64'h2A, 64'd0, 5'd5, 32'h8000_0000);
        #1;
        chk("addi_allowin", {63'd0, mem_allowin}, 64'd1);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk("addi_valid",  {63'd0, mem_to_wb_valid}, 64'd1);
        chk("addi_result", mem_to_wb_result, 64'h2A);
        chk("addi_rd",     {59'd0, mem_to_wb_rd}, 64'd5);
        chk("addi_req",    {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("addi_fwd",    {63'd0, mem_fwd_valid}, 64'd1);
        chk("addi_pc",     {32'd0, mem_to_wb_pc}, 64'h8000_0000);
        next_cyc();
        #1;
        chk("addi_gone",   {63'd0, mem_to_wb_valid}, 64'd0);

        // lb at 0x1003: grant at once, rvalid next cycle
        issue(1'b1, 1'b0, 1'b1, 3'b000, 64'h1003, 64'd0, 5'd6, 32'h8000_0004);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        chk("lb_req",     {63'd0, dmem_bus.dmem_req}, 64'd1);
        chk("lb_addr",    dmem_bus.dmem_addr, 64'h1000);
        chk("lb_we",      {63'd0, dmem_bus.dmem_we}, 64'd0);
        chk("lb_allowin", {63'd0, mem_allowin}, 64'd0);
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata = 64'h0000_0000_8000_0000;
        #1;
        chk("lb_early", {63'd0, mem_to_wb_valid}, 64'd0);
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        // lbu at the same address accepted in the handoff cycle
        issue(1'b1, 1'b0, 1'b1, 3'b100, 64'h1003, 64'd0, 5'd7, 32'h8000_0008);
        #1;
        chk("lb_valid",   {63'd0, mem_to_wb_valid}, 64'd1);
        chk("lb_result",  mem_to_wb_result, 64'hFFFF_FFFF_FFFF_FF80);
        chk("b2b_allowin", {63'd0, mem_allowin}, 64'd1);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        chk("lbu_req",   {63'd0, dmem_bus.dmem_req}, 64'd1);
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        #1;
        chk("lbu_valid",  {63'd0, mem_to_wb_valid}, 64'd1);
        chk("lbu_result", mem_to_wb_result, 64'h80);
        next_cyc();

        // sh at 0x2006
        issue(1'b0, 1'b1, 1'b0, 3'b001, 64'h2006, 64'hBEEF, 5'd0, 32'h8000_000C);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        chk("sh_addr",  dmem_bus.dmem_addr, 64'h2000);
        chk("sh_wstrb", {56'd0, dmem_bus.dmem_wstrb}, 64'hC0);
        chk("sh_wdata", dmem_bus.dmem_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_we",    {63'd0, dmem_bus.dmem_we}, 64'd1);
        chk("sh_misal", {63'd0, mem_misalign}, 64'd0);
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        #1;
        chk("sh_valid", {63'd0, mem_to_wb_valid}, 64'd1);
        chk("sh_wen",   {63'd0, mem_to_wb_wen}, 64'd0);
        next_cyc();

        // ld with grant withheld for 4 cycles
        issue(1'b1, 1'b0, 1'b1, 3'b011, 64'h4010, 64'd0, 5'd8, 32'h8000_0010);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_req",     {63'd0, dmem_bus.dmem_req}, 64'd1);
            chk("stall_addr",    dmem_bus.dmem_addr, 64'h4010);
            chk("stall_allowin", {63'd0, mem_allowin}, 64'd0);
            next_cyc();
        end
        dmem_bus.dmem_gnt = 1'b1;
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata = 64'h1122_3344_5566_7788;
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        #1;
        chk("ld_result", mem_to_wb_result, 64'h1122_3344_5566_7788);
        next_cyc();

        // Flush during WAIT drains the response
        issue(1'b1, 1'b0, 1'b1, 3'b010, 64'h5000, 64'd0, 5'd9, 32'h8000_0014);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        mem_flush = 1'b1;
        #1;
        chk("fw_fwd",     {63'd0, mem_fwd_valid}, 64'd0);
        next_cyc();
        mem_flush = 1'b0;
        #1;
        chk("fw_allowin1", {63'd0, mem_allowin}, 64'd0);
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b1;
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        #1;
        chk("fw_valid",    {63'd0, mem_to_wb_valid}, 64'd0);
        chk("fw_allowin2", {63'd0, mem_allowin}, 64'd0);
        next_cyc();
        #1;
        chk("fw_allowin3", {63'd0, mem_allowin}, 64'd1);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 64'h77, 64'd0, 5'd9, 32'h8000_0018);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        #1;
        chk("fw_next_valid",  {63'd0, mem_to_wb_valid}, 64'd1);
        chk("fw_next_result", mem_to_wb_result, 64'h77);
        next_cyc();

        // Flush in REQ with no grant drops the request at once
        issue(1'b1, 1'b0, 1'b1, 3'b010, 64'h5008, 64'd0, 5'd10, 32'h8000_001C);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        mem_flush = 1'b1;
        next_cyc();
        mem_flush = 1'b0;
        #1;
        chk("fr_req",     {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("fr_allowin", {63'd0, mem_allowin}, 64'd1);

        // Flush together with capture discards the incoming instruction
        issue(1'b0, 1'b0, 1'b1, 3'b000, 64'h55, 64'd0, 5'd11, 32'h8000_0020);
        mem_flush = 1'b1;
        next_cyc();
        ex_to_mem_valid = 1'b0;
        mem_flush = 1'b0;
        #1;
        chk("fc_valid", {63'd0, mem_to_wb_valid}, 64'd0);

        // Misaligned lw at 0x3006, then reset during WAIT
        issue(1'b1, 1'b0, 1'b1, 3'b010, 64'h3006, 64'd0, 5'd12, 32'h8000_0024);
        next_cyc();
        ex_to_mem_valid = 1'b0;
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        chk("mis_flag",  {63'd0, mem_misalign}, 64'd1);
        chk("mis_wstrb", {56'd0, dmem_bus.dmem_wstrb}, 64'hC0);
        next_cyc();
        dmem_bus.dmem_gnt = 1'b0;
        rst = 1'b0;
        next_cyc();
        #1;
        chk("mr_req",     {63'd0, dmem_bus.dmem_req}, 64'd0);
        chk("mr_valid",   {63'd0, mem_to_wb_valid}, 64'd0);
        chk("mr_fwd",     {63'd0, mem_fwd_valid}, 64'd0);
        chk("mr_misal",   {63'd0, mem_misalign}, 64'd0);
        chk("mr_allowin", {63'd0, mem_allowin}, 64'd1);
        rst = 1'b1;
        dmem_bus.dmem_rvalid = 1'b1;
        next_cyc();
        dmem_bus.dmem_rvalid = 1'b0;
        next_cyc();
        #1;
        chk("late_valid", {63'd0, mem_to_wb_valid}, 64'd0);
        chk("late_req",   {63'd0, dmem_bus.dmem_req}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
